// File: rtl/stream_avg_if.sv
// Stream interface for stream_avg_tree: sample beats in, one averaged result out.
// A transfer happens on a rising clk edge where valid and ready are both high; the
// producer holds valid and its payload steady until that edge, and ready may not wait on valid.
interface stream_avg_if #(
  parameter int NCH   = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 32
);
  localparam int SW = DW + $clog2(NCH * DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_avg;
  logic [SW-1:0]     out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_avg, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_avg, out_sum
  );
endinterface

// File: rtl/stream_avg_tree.sv
// Multi-channel frame averager: sums NCH samples per beat, accumulates DEPTH beats,
// and presents the rounded mean plus the raw sum over a valid/ready result port.
module stream_avg_tree #(
  parameter int NCH   = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     clear,
  stream_avg_if.slave              bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   beat_cnt,
  output logic [1:0]               dbg_state
);

  localparam int S  = $clog2(NCH * DEPTH);
  localparam int SW = DW + S;
  localparam int BW = DW + $clog2(NCH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);
  localparam logic [SW-1:0] HALF      = SW'(1) << (S - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FLUSH  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t            state_q;
  logic              cont_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        flush_q;
  logic [NCH*DW-1:0] data_q;
  logic              dv_q;
  logic [BW-1:0]     sum_q;
  logic              sv_q;
  logic [SW-1:0]     acc_q;
  logic [SW-1:0]     osum_q;
  logic [DW-1:0]     avg_q;
  logic [BW-1:0]     beat_sum_d;

  // Reduction of one registered beat; synthesis balances this into an adder tree.
  always_comb begin
    beat_sum_d = '0;
    for (int k = 0; k < NCH; k++) begin
      beat_sum_d = beat_sum_d + BW'(data_q[k*DW +: DW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      flush_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      sum_q   <= '0;
      sv_q    <= 1'b0;
      acc_q   <= '0;
      osum_q  <= '0;
      avg_q   <= '0;
    end else begin
      dv_q <= 1'b0;
      sv_q <= dv_q;
      if (dv_q) sum_q <= beat_sum_d;
      if (sv_q) acc_q <= acc_q + SW'(sum_q);

      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        flush_q <= '0;
        acc_q   <= '0;
        dv_q    <= 1'b0;
        sv_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= ACCUM;
              cont_q  <= cont;
              cnt_q   <= '0;
              acc_q   <= '0;
            end
          end
          ACCUM: begin
            if (bus.in_valid) begin
              data_q <= bus.in_data;
              dv_q   <= 1'b1;
              cnt_q  <= cnt_q + CW'(1);
              if (cnt_q == LAST_BEAT) begin
                state_q <= FLUSH;
                flush_q <= '0;
              end
            end
          end
          FLUSH: begin
            // Last beat lands in the accumulator two edges after entry; load on the third.
            if (flush_q == 2'd2) begin
              state_q <= RESULT;
              osum_q  <= acc_q;
              avg_q   <= DW'((acc_q + HALF) >> S);
            end else begin
              flush_q <= flush_q + 2'd1;
            end
          end
          RESULT: begin
            if (bus.out_ready) begin
              if (cont_q) begin
                state_q <= ACCUM;
                cnt_q   <= '0;
                acc_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == RESULT);
  assign bus.out_avg   = avg_q;
  assign bus.out_sum   = osum_q;
  assign busy          = (state_q != IDLE);
  assign beat_cnt      = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stream_avg_tree.sv
// Self-checking bench for stream_avg_tree: reset, table-driven frames, backpressure,
// continuous mode, aborts, randomized frames against a plain-arithmetic model.
module tb_stream_avg_tree;

  localparam int NCH   = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int N     = NCH * DEPTH;
  localparam int SW    = DW + $clog2(N);

  typedef struct {
    int unsigned fill;
    int unsigned spike_val;
    int unsigned spike_cnt;
    int unsigned exp_sum;
    int unsigned exp_avg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cont = 1'b0, clear = 1'b0;
  logic       busy;
  logic [5:0] beat_cnt;
  logic [1:0] dbg_state;
  logic       start1 = 1'b0, cont1 = 1'b0, clear1 = 1'b0;
  logic       busy1;
  logic [2:0] beat_cnt1;
  logic [1:0] dbg_state1;

  int checks = 0;
  int errors = 0;

  logic [NCH*DW-1:0] frame_mem [DEPTH];
  logic [SW-1:0]     exp_q [$];
  vec_t              vecs [6];

  stream_avg_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus0 ();
  stream_avg_if #(.NCH(4), .DW(12), .DEPTH(4))       bus1 ();

  stream_avg_tree #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .clear(clear),
    .bus(bus0), .busy(busy), .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  stream_avg_tree #(.NCH(4), .DW(12), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .clear(clear1),
    .bus(bus1), .busy(busy1), .beat_cnt(beat_cnt1), .dbg_state(dbg_state1)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic fill_frame(input int unsigned fill, input int unsigned sv, input int unsigned sc);
    for (int b = 0; b < DEPTH; b++)
      for (int k = 0; k < NCH; k++)
        frame_mem[b][k*DW +: DW] = DW'(((b * NCH + k) < sc) ? sv : fill);
  endtask

  task automatic rand_frame();
    for (int b = 0; b < DEPTH; b++)
      for (int k = 0; k < NCH; k++)
        frame_mem[b][k*DW +: DW] = DW'($urandom_range(255));
  endtask

  function automatic int unsigned model_sum();
    int unsigned s = 0;
    for (int b = 0; b < DEPTH; b++)
      for (int k = 0; k < NCH; k++)
        s += 32'(frame_mem[b][k*DW +: DW]);
    return s;
  endfunction

  function automatic int unsigned model_avg(input int unsigned s);
    return (s + N / 2) / N;
  endfunction

  task automatic do_start(input logic c);
    start = 1'b1;
    cont  = c;
    tick();
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic send_beats(input int n, input int stall_pct);
    int  idx = 0;
    int  guard = 0;
    logic acc;
    while (idx < n && guard < 5000) begin
      bus0.in_valid = ($urandom_range(99) >= stall_pct);
      bus0.in_data  = bus0.in_valid ? frame_mem[idx] : {$urandom, $urandom};
      acc = bus0.in_valid && bus0.in_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    bus0.in_valid = 1'b0;
    if (idx < n) check("send_timeout", idx, n);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus0.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!bus0.out_valid) check("result_timeout", 0, 1);
  endtask

  task automatic handshake();
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int unsigned s;
    int unsigned got_sum;
    logic        seen;
    int          n, g;
    logic        acc;

    vecs[0] = '{255, 0,   0,   65280, 255};
    vecs[1] = '{0,   128, 1,   128,   1};
    vecs[2] = '{0,   127, 1,   127,   0};
    vecs[3] = '{0,   128, 3,   384,   2};
    vecs[4] = '{10,  0,   0,   2560,  10};
    vecs[5] = '{0,   255, 128, 32640, 128};

    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", bus0.in_ready, 0);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_avg", bus0.out_avg, 0);
    check("rst_out_sum", bus0.out_sum, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    tick();

    // in_valid outside ACCUM is ignored
    bus0.in_valid = 1'b1;
    repeat (3) tick();
    bus0.in_valid = 1'b0;
    check("idle_ignore_valid", beat_cnt, 0);

    // Table-driven one-shot frames
    for (int i = 0; i < 6; i++) begin
      fill_frame(vecs[i].fill, vecs[i].spike_val, vecs[i].spike_cnt);
      do_start(1'b0);
      check("busy_after_start", busy, 1);
      send_beats(DEPTH, 0);
      check("beat_cnt_full", beat_cnt, DEPTH);
      wait_result(lat);
      check("result_latency", lat, 3);
      check("vec_sum", bus0.out_sum, vecs[i].exp_sum);
      check("vec_avg", bus0.out_avg, vecs[i].exp_avg);
      handshake();
      check("idle_after_oneshot", busy, 0);
    end

    // Backpressure: result held stable while out_ready is low
    rand_frame();
    s = model_sum();
    do_start(1'b0);
    send_beats(DEPTH, 0);
    wait_result(lat);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_sum_stable", bus0.out_sum, s);
      check("bp_avg_stable", bus0.out_avg, model_avg(s));
      check("bp_valid_held", bus0.out_valid, 1);
      check("bp_in_ready_low", bus0.in_ready, 0);
    end
    handshake();
    check("bp_busy_after_hs", busy, 0);
    check("bp_valid_after_hs", bus0.out_valid, 0);

    // Randomized frames, each sent unstalled and then with random stalls
    for (int r = 0; r < 4; r++) begin
      rand_frame();
      for (int pass = 0; pass < 2; pass++) begin
        exp_q.push_back(SW'(model_sum()));
        do_start(1'b0);
        send_beats(DEPTH, (pass == 0) ? 0 : $urandom_range(70, 20));
        wait_result(lat);
        got_sum = bus0.out_sum;
        s = exp_q.pop_front();
        check("rand_sum", got_sum, s);
        check("rand_avg", bus0.out_avg, model_avg(s));
        handshake();
      end
    end

    // Continuous mode: frame A then frame B
    fill_frame(10, 0, 0);
    do_start(1'b1);
    send_beats(DEPTH, 0);
    wait_result(lat);
    check("cont_a_avg", bus0.out_avg, 10);
    check("cont_a_sum", bus0.out_sum, 2560);
    handshake();
    check("cont_in_ready_back", bus0.in_ready, 1);
    check("cont_beat_cnt_zero", beat_cnt, 0);
    fill_frame(20, 0, 0);
    send_beats(DEPTH, 10);
    wait_result(lat);
    check("cont_b_avg", bus0.out_avg, 20);
    check("cont_b_sum", bus0.out_sum, 5120);
    // clear in RESULT wins over a simultaneous handshake
    clear = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    clear = 1'b0;
    bus0.out_ready = 1'b0;
    check("clear_result_valid", bus0.out_valid, 0);
    check("clear_result_busy", busy, 0);

    // Abort after 17 beats
    rand_frame();
    do_start(1'b0);
    send_beats(17, 0);
    check("partial_beat_cnt", beat_cnt, 17);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_beat_cnt", beat_cnt, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus0.out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", seen, 0);

    // start and clear together: stays idle
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("start_clear_idle", busy, 0);
    tick();
    check("start_clear_idle2", busy, 0);

    // Reset pulse during FLUSH
    fill_frame(255, 0, 0);
    do_start(1'b0);
    send_beats(DEPTH, 0);
    tick();
    check("flush_busy", busy, 1);
    check("flush_in_ready", bus0.in_ready, 0);
    rst = 1'b1;
    #1;
    check("arst_out_sum", bus0.out_sum, 0);
    check("arst_out_avg", bus0.out_avg, 0);
    check("arst_busy", busy, 0);
    check("arst_beat_cnt", beat_cnt, 0);
    check("arst_out_valid", bus0.out_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    fill_frame(0, 128, 3);
    do_start(1'b0);
    send_beats(DEPTH, 0);
    wait_result(lat);
    check("post_rst_sum", bus0.out_sum, 384);
    check("post_rst_avg", bus0.out_avg, 2);
    handshake();

    // Second parameter set: NCH=4, DW=12, DEPTH=4 at full scale
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = '1;
    n = 0;
    g = 0;
    while (n < 4 && g < 50) begin
      acc = bus1.in_ready;
      tick();
      if (acc) n++;
      g++;
    end
    bus1.in_valid = 1'b0;
    check("p2_beats", n, 4);
    g = 0;
    while (!bus1.out_valid && g < 50) begin
      tick();
      g++;
    end
    check("p2_valid", bus1.out_valid, 1);
    check("p2_sum", bus1.out_sum, 65520);
    check("p2_avg", bus1.out_avg, 4095);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("p2_idle", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
